// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants and types for the MIPS pipeline control unit.
//   - opcode / func field values for the supported instruction subset
//   - ALU operation encodings carried in the control bundle
//   - control bundle layout (packed struct), its width and bit positions
//   - EX-stage forwarding select values
package mips_ctrl_pkg;

  localparam int unsigned CTRL_W = 12;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned FUNC_W = 6;
  localparam int unsigned FWD_W  = 2;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type func codes; func 0 (sll) is treated as nop
  localparam logic [FUNC_W-1:0] FN_NOP = 6'h00;
  localparam logic [FUNC_W-1:0] FN_JR  = 6'h08;
  localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNC_W-1:0] FN_SLT = 6'h2A;

  // ALU operation requested from the EX stage
  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_FUNC = 2'd2,
    ALU_NOP  = 2'd3
  } alu_op_e;

  // Control bundle, MSB first
  typedef struct packed {
    logic    reg_dst;
    logic    jal;
    logic    reg_write;
    logic    slt;
    logic    alu_src;
    alu_op_e alu_op;
    logic    branch;
    logic    jump;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
  } ctrl_t;

  // Bit positions of the bundle fields when viewed as a flat vector
  localparam int unsigned B_REG_DST    = 11;
  localparam int unsigned B_JAL        = 10;
  localparam int unsigned B_REG_WRITE  = 9;
  localparam int unsigned B_SLT        = 8;
  localparam int unsigned B_ALU_SRC    = 7;
  localparam int unsigned B_ALU_OP_HI  = 6;
  localparam int unsigned B_ALU_OP_LO  = 5;
  localparam int unsigned B_BRANCH     = 4;
  localparam int unsigned B_JUMP       = 3;
  localparam int unsigned B_MEM_READ   = 2;
  localparam int unsigned B_MEM_WRITE  = 1;
  localparam int unsigned B_MEM_TO_REG = 0;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Forwarding selects for the EX operands
  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational decode of the ID-stage instruction.
//   id_inst, id_valid  : instruction in IF/ID and its valid flag
//   ctrl_c             : control bundle (bubble for invalid/undecodable)
//   dst_c              : write destination (rd, link register or rt)
//   use_rs_c, use_rt_c : the instruction reads rs / rt
//   jr_c               : jr in ID, jump target comes from rs
//   illegal_c          : valid instruction that does not decode
module ctrl_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LINK_REG = 31
) (
  input  logic [31:0]       id_inst,
  input  logic              id_valid,
  output ctrl_t             ctrl_c,
  output logic [REG_AW-1:0] dst_c,
  output logic              use_rs_c,
  output logic              use_rt_c,
  output logic              jr_c,
  output logic              illegal_c
);

  logic [OP_W-1:0]   opcode;
  logic [FUNC_W-1:0] func;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              legal;
  logic              unused_fields;

  assign opcode = id_inst[31:26];
  assign func   = id_inst[5:0];
  assign rt     = REG_AW'(id_inst[20:16]);
  assign rd     = REG_AW'(id_inst[15:11]);

  // rs is sliced by the top; shamt is never needed
  assign unused_fields = ^{id_inst[25:21], id_inst[10:6]};

  // Opcode/func decode; anything unrecognised collapses to a bubble
  always_comb begin
    ctrl_c    = CTRL_BUBBLE;
    dst_c     = '0;
    use_rs_c  = 1'b0;
    use_rt_c  = 1'b0;
    jr_c      = 1'b0;
    illegal_c = 1'b0;
    legal     = 1'b1;

    case (opcode)
      OP_RTYPE: begin
        dst_c = rd;
        case (func)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            ctrl_c.reg_dst   = 1'b1;
            ctrl_c.reg_write = 1'b1;
            ctrl_c.slt       = (func == FN_SLT);
            ctrl_c.alu_op    = ALU_FUNC;
            use_rs_c         = 1'b1;
            use_rt_c         = 1'b1;
          end
          FN_JR: begin
            ctrl_c.jump   = 1'b1;
            ctrl_c.alu_op = ALU_FUNC;
            use_rs_c      = 1'b1;
            jr_c          = 1'b1;
          end
          FN_NOP: begin
            ctrl_c.alu_op = ALU_NOP;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_ADD;
        dst_c            = rt;
        use_rs_c         = 1'b1;
      end
      OP_SLTI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.slt       = 1'b1;
        ctrl_c.alu_op    = ALU_SUB;
        dst_c            = rt;
        use_rs_c         = 1'b1;
      end
      OP_LW: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.alu_op     = ALU_ADD;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        dst_c             = rt;
        use_rs_c          = 1'b1;
      end
      OP_SW: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.mem_write = 1'b1;
        dst_c            = rt;
        use_rs_c         = 1'b1;
        use_rt_c         = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.alu_op = ALU_SUB;
        dst_c         = rt;
        use_rs_c      = 1'b1;
        use_rt_c      = 1'b1;
      end
      OP_J: begin
        ctrl_c.jump   = 1'b1;
        ctrl_c.alu_op = ALU_NOP;
        dst_c         = rt;
      end
      OP_JAL: begin
        ctrl_c.jump      = 1'b1;
        ctrl_c.jal       = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = ALU_NOP;
        dst_c            = REG_AW'(LINK_REG);
      end
      default: legal = 1'b0;
    endcase

    // Invalid or undecodable slots become a bubble with dst 0
    if (!id_valid || !legal) begin
      ctrl_c   = CTRL_BUBBLE;
      dst_c    = '0;
      use_rs_c = 1'b0;
      use_rt_c = 1'b0;
      jr_c     = 1'b0;
    end
    illegal_c = id_valid && !legal;
  end

endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: control path of the 5-stage MIPS pipeline.
//   clk, rst_n             : clock, async active-low reset
//   id_inst, id_valid      : instruction in IF/ID
//   ex_br_taken            : BEQ in EX resolved taken
//   id_jump, id_jr         : PC mux selects for J/JAL/JR (combinational)
//   pc_hold, ifid_hold     : freeze PC and IF/ID on a hazard (combinational)
//   ifid_flush             : zero IF/ID on the next edge (combinational)
//   ex_ctrl/mem_ctrl/wb_ctrl : control bundle per stage register
//   ex_rs, ex_rt           : sources of the EX instruction (0 when unused)
//   mem_dst, wb_dst        : write destinations in MEM and WB
//   fwd_a, fwd_b           : EX operand forwarding selects
//   illegal                : sticky undecodable-instruction flag
module pipe_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned FWD_EN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       id_inst,
  input  logic              id_valid,
  input  logic              ex_br_taken,
  output logic              id_jump,
  output logic              id_jr,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output ctrl_t             ex_ctrl,
  output ctrl_t             mem_ctrl,
  output ctrl_t             wb_ctrl,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] mem_dst,
  output logic [REG_AW-1:0] wb_dst,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              illegal
);

  ctrl_t             dec_ctrl;
  logic [REG_AW-1:0] dec_dst;
  logic              dec_use_rs;
  logic              dec_use_rt;
  logic              dec_jr;
  logic              dec_illegal;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] ex_dst;

  logic load_use_c;
  logic jr_stall_c;
  logic raw_stall_c;
  logic stall_c;
  logic bubble_c;

  assign id_rs = REG_AW'(id_inst[25:21]);
  assign id_rt = REG_AW'(id_inst[20:16]);

  ctrl_decoder #(
    .REG_AW   (REG_AW),
    .LINK_REG (LINK_REG)
  ) u_dec (
    .id_inst   (id_inst),
    .id_valid  (id_valid),
    .ctrl_c    (dec_ctrl),
    .dst_c     (dec_dst),
    .use_rs_c  (dec_use_rs),
    .use_rt_c  (dec_use_rt),
    .jr_c      (dec_jr),
    .illegal_c (dec_illegal)
  );

  // A stage produces src when it writes a non-zero register equal to src
  function automatic logic hit(input logic wr, input logic [REG_AW-1:0] dst,
                               input logic [REG_AW-1:0] src);
    return wr && (dst != '0) && (dst == src);
  endfunction

  // Hazard detection and ID-stage pipeline steering
  always_comb begin
    load_use_c  = ex_ctrl.mem_read &&
                  ((dec_use_rs && hit(1'b1, ex_dst, id_rs)) ||
                   (dec_use_rt && hit(1'b1, ex_dst, id_rt)));
    // jr reads rs in ID, before any forwarding path exists
    jr_stall_c  = dec_jr &&
                  (hit(ex_ctrl.reg_write, ex_dst, id_rs) ||
                   hit(mem_ctrl.reg_write, mem_dst, id_rs));
    raw_stall_c = 1'b0;
    if (FWD_EN == 32'd0) begin
      raw_stall_c = (dec_use_rs && (hit(ex_ctrl.reg_write, ex_dst, id_rs) ||
                                    hit(mem_ctrl.reg_write, mem_dst, id_rs))) ||
                    (dec_use_rt && (hit(ex_ctrl.reg_write, ex_dst, id_rt) ||
                                    hit(mem_ctrl.reg_write, mem_dst, id_rt)));
    end
    // A taken branch kills the ID instruction, so it overrides any stall
    stall_c    = (load_use_c || jr_stall_c || raw_stall_c) && !ex_br_taken;
    id_jump    = dec_ctrl.jump && !stall_c && !ex_br_taken;
    id_jr      = dec_jr;
    pc_hold    = stall_c;
    ifid_hold  = stall_c;
    ifid_flush = ex_br_taken || id_jump;
    bubble_c   = ex_br_taken || stall_c;
  end

  // Stage registers: ID/EX may take a bubble, EX/MEM and MEM/WB always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl  <= CTRL_BUBBLE;
      ex_dst   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      mem_ctrl <= CTRL_BUBBLE;
      mem_dst  <= '0;
      wb_ctrl  <= CTRL_BUBBLE;
      wb_dst   <= '0;
      illegal  <= 1'b0;
    end else begin
      if (bubble_c) begin
        ex_ctrl <= CTRL_BUBBLE;
        ex_dst  <= '0;
        ex_rs   <= '0;
        ex_rt   <= '0;
      end else begin
        ex_ctrl <= dec_ctrl;
        ex_dst  <= dec_dst;
        // Unused source fields are zeroed so they never select a forward
        ex_rs   <= dec_use_rs ? id_rs : '0;
        ex_rt   <= dec_use_rt ? id_rt : '0;
      end
      mem_ctrl <= ex_ctrl;
      mem_dst  <= ex_dst;
      wb_ctrl  <= mem_ctrl;
      wb_dst   <= mem_dst;
      if (dec_illegal) begin
        illegal <= 1'b1;
      end
    end
  end

  // EX operand forwarding: the younger MEM result wins over WB
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (FWD_EN != 32'd0) begin
      if (hit(mem_ctrl.reg_write, mem_dst, ex_rs)) begin
        fwd_a = FWD_MEM;
      end else if (hit(wb_ctrl.reg_write, wb_dst, ex_rs)) begin
        fwd_a = FWD_WB;
      end
      if (hit(mem_ctrl.reg_write, mem_dst, ex_rt)) begin
        fwd_b = FWD_MEM;
      end else if (hit(wb_ctrl.reg_write, wb_dst, ex_rt)) begin
        fwd_b = FWD_WB;
      end
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: decode table, directed hazard
// sequences and a randomized instruction stream against a reference model.
module tb_pipe_control_unit;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned LINK_REG = 31;
  localparam int unsigned FWD_EN   = 1;

  // Expected whole bundles, layout {reg_dst,jal,reg_write,slt,alu_src,alu_op,branch,jump,mem_read,mem_write,mem_to_reg}
  localparam logic [11:0] C_ARITH = 12'hA40;
  localparam logic [11:0] C_SLT   = 12'hB40;
  localparam logic [11:0] C_ADDI  = 12'h280;
  localparam logic [11:0] C_SLTI  = 12'h3A0;
  localparam logic [11:0] C_LW    = 12'h285;
  localparam logic [11:0] C_SW    = 12'h082;
  localparam logic [11:0] C_BEQ   = 12'h030;
  localparam logic [11:0] C_J     = 12'h068;
  localparam logic [11:0] C_JAL   = 12'h668;
  localparam logic [11:0] C_JR    = 12'h048;
  localparam logic [11:0] C_NOP   = 12'h060;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        ex_br_taken;
  logic        id_jump, id_jr, pc_hold, ifid_hold, ifid_flush;
  logic [11:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_rs, ex_rt, mem_dst, wb_dst;
  logic [1:0]  fwd_a, fwd_b;
  logic        illegal;

  always #5 clk = ~clk;

  pipe_control_unit #(
    .REG_AW(REG_AW), .LINK_REG(LINK_REG), .FWD_EN(FWD_EN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .ex_br_taken(ex_br_taken), .id_jump(id_jump), .id_jr(id_jr),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Reference decode: what each instruction means, by mnemonic
  typedef struct {
    logic        legal;
    logic [11:0] ctrl;
    logic [4:0]  dst;
    logic        use_rs, use_rt, jump, jr;
    logic [4:0]  rs, rt;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] w, input logic v);
    dec_t d;
    logic [5:0] op, fn;
    logic [4:0] rd;
    d = '{default: '0};
    op = w[31:26]; fn = w[5:0]; rd = w[15:11];
    d.rs = w[25:21]; d.rt = w[20:16]; d.legal = 1'b1;
    case (op)
      6'h00: case (fn)
        6'h20, 6'h22, 6'h24, 6'h25: begin d.ctrl = C_ARITH; d.dst = rd; d.use_rs = 1; d.use_rt = 1; end
        6'h2A: begin d.ctrl = C_SLT; d.dst = rd; d.use_rs = 1; d.use_rt = 1; end
        6'h08: begin d.ctrl = C_JR; d.dst = rd; d.use_rs = 1; d.jr = 1; end
        6'h00: begin d.ctrl = C_NOP; d.dst = rd; end
        default: d.legal = 1'b0;
      endcase
      6'h08: begin d.ctrl = C_ADDI; d.dst = d.rt; d.use_rs = 1; end
      6'h0A: begin d.ctrl = C_SLTI; d.dst = d.rt; d.use_rs = 1; end
      6'h23: begin d.ctrl = C_LW;   d.dst = d.rt; d.use_rs = 1; end
      6'h2B: begin d.ctrl = C_SW;   d.dst = d.rt; d.use_rs = 1; d.use_rt = 1; end
      6'h04: begin d.ctrl = C_BEQ;  d.dst = d.rt; d.use_rs = 1; d.use_rt = 1; end
      6'h02: begin d.ctrl = C_J;    d.dst = d.rt; end
      6'h03: begin d.ctrl = C_JAL;  d.dst = 5'(LINK_REG); end
      default: d.legal = 1'b0;
    endcase
    if (!v || !d.legal) begin
      d.ctrl = '0; d.dst = '0; d.use_rs = 0; d.use_rt = 0; d.jr = 0;
    end
    d.jump = (d.ctrl == C_J) || (d.ctrl == C_JAL) || (d.ctrl == C_JR);
    return d;
  endfunction

  // Model of what sits in each stage register
  typedef struct {
    logic [11:0] ctrl;
    logic [4:0]  dst, rs, rt;
  } stage_t;

  stage_t m_ex, m_mem, m_wb;
  logic   m_ill;
  logic   last_hold, last_flush;

  function automatic logic writes(input stage_t s, input logic [4:0] r);
    return s.ctrl[9] && (s.dst != 0) && (s.dst == r);
  endfunction

  function automatic logic [1:0] fwd_for(input logic [4:0] r);
    if (FWD_EN == 0) return 2'b00;
    if (writes(m_mem, r)) return 2'b10;
    if (writes(m_wb, r)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex = '{default: '0}; m_mem = '{default: '0}; m_wb = '{default: '0};
    m_ill = 1'b0; last_hold = 1'b0; last_flush = 1'b0;
  endtask

  task automatic drive(input logic [31:0] inst, input logic v, input logic br);
    id_inst = inst; id_valid = v; ex_br_taken = br;
    #1;
  endtask

  // One cycle: drive, compare every output with the model, clock, advance model
  task automatic step(input logic [31:0] inst, input logic v, input logic br);
    dec_t   d;
    stage_t nx;
    logic   hz, stall, jmp, flush;
    drive(inst, v, br);
    d  = ref_decode(inst, v);
    hz = 1'b0;
    if (m_ex.ctrl[2] && m_ex.dst != 0 &&
        ((d.use_rs && m_ex.dst == d.rs) || (d.use_rt && m_ex.dst == d.rt))) hz = 1'b1;
    if (d.jr && (writes(m_ex, d.rs) || writes(m_mem, d.rs))) hz = 1'b1;
    if (FWD_EN == 0 && ((d.use_rs && (writes(m_ex, d.rs) || writes(m_mem, d.rs))) ||
                        (d.use_rt && (writes(m_ex, d.rt) || writes(m_mem, d.rt))))) hz = 1'b1;
    stall = hz && !br;
    jmp   = d.jump && !stall && !br;
    flush = br || jmp;
    chk("comb{jump,jr,pc_hold,ifid_hold,flush}",
        32'({id_jump, id_jr, pc_hold, ifid_hold, ifid_flush}), 32'({jmp, d.jr, stall, stall, flush}));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ex.ctrl));
    chk("mem_ctrl", 32'(mem_ctrl), 32'(m_mem.ctrl));
    chk("wb_ctrl", 32'(wb_ctrl), 32'(m_wb.ctrl));
    chk("ex_rs_rt", 32'({ex_rs, ex_rt}), 32'({m_ex.rs, m_ex.rt}));
    chk("mem_wb_dst", 32'({mem_dst, wb_dst}), 32'({m_mem.dst, m_wb.dst}));
    chk("fwd_ab", 32'({fwd_a, fwd_b}), 32'({fwd_for(m_ex.rs), fwd_for(m_ex.rt)}));
    chk("illegal", 32'(illegal), 32'(m_ill));
    nx = '{default: '0};
    if (!stall && !br) begin
      nx.ctrl = d.ctrl; nx.dst = d.dst;
      nx.rs = d.use_rs ? d.rs : 5'd0;
      nx.rt = d.use_rt ? d.rt : 5'd0;
    end
    last_hold = stall; last_flush = flush;
    @(posedge clk);
    m_wb = m_mem; m_mem = m_ex; m_ex = nx;
    if (v && !d.legal) m_ill = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) step(32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    int k;
    k = int'($urandom_range(0, 13));
    case (k)
      0:  return rtype($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 6'h20);
      1:  return rtype($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 6'h22);
      2:  return rtype($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 6'h24);
      3:  return rtype($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 6'h25);
      4:  return rtype($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 6'h2A);
      5:  return rtype($urandom_range(0,7), 0, 0, 6'h08);
      6:  return 32'h0;
      7:  return itype(6'h08, $urandom_range(0,7), $urandom_range(0,7), 16'($urandom));
      8:  return itype(6'h0A, $urandom_range(0,7), $urandom_range(0,7), 16'($urandom));
      9:  return itype(6'h23, $urandom_range(0,7), $urandom_range(0,7), 16'($urandom));
      10: return itype(6'h2B, $urandom_range(0,7), $urandom_range(0,7), 16'($urandom));
      11: return itype(6'h04, $urandom_range(0,7), $urandom_range(0,7), 16'($urandom));
      12: return jtype(6'h02, 26'($urandom));
      default: return jtype(6'h03, 26'($urandom));
    endcase
  endfunction

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [11:0] ctrl;
    logic [4:0]  dst;
    logic        jump;
  } vec_t;

  vec_t        tbl[14];
  logic [31:0] add3, lw5, add6, cur_inst;
  logic        cur_v, br;

  initial begin
    tbl[0]  = '{"add",  rtype(1, 2, 3, 6'h20),          C_ARITH, 5'd3,  1'b0};
    tbl[1]  = '{"sub",  rtype(1, 2, 4, 6'h22),          C_ARITH, 5'd4,  1'b0};
    tbl[2]  = '{"and",  rtype(1, 2, 5, 6'h24),          C_ARITH, 5'd5,  1'b0};
    tbl[3]  = '{"or",   rtype(3, 4, 12, 6'h25),         C_ARITH, 5'd12, 1'b0};
    tbl[4]  = '{"slt",  rtype(1, 2, 6, 6'h2A),          C_SLT,   5'd6,  1'b0};
    tbl[5]  = '{"addi", itype(6'h08, 1, 7, 16'h0005),   C_ADDI,  5'd7,  1'b0};
    tbl[6]  = '{"slti", itype(6'h0A, 2, 8, 16'hFFFF),   C_SLTI,  5'd8,  1'b0};
    tbl[7]  = '{"lw",   itype(6'h23, 1, 10, 16'h0004),  C_LW,    5'd10, 1'b0};
    tbl[8]  = '{"sw",   itype(6'h2B, 2, 11, 16'h0008),  C_SW,    5'd11, 1'b0};
    tbl[9]  = '{"beq",  itype(6'h04, 1, 2, 16'h0003),   C_BEQ,   5'd2,  1'b0};
    tbl[10] = '{"j",    jtype(6'h02, 26'h0000100),      C_J,     5'd0,  1'b1};
    tbl[11] = '{"jal",  jtype(6'h03, 26'h0000040),      C_JAL,   5'd31, 1'b1};
    tbl[12] = '{"jr",   rtype(9, 0, 0, 6'h08),          C_JR,    5'd0,  1'b1};
    tbl[13] = '{"nop",  32'h0,                          C_NOP,   5'd0,  1'b0};

    add3 = rtype(1, 2, 3, 6'h20);
    lw5  = itype(6'h23, 1, 5, 16'h0000);
    add6 = rtype(5, 2, 6, 6'h20);

    // Reset with a valid add held in ID
    model_reset();
    rst_n = 1'b0; id_inst = add3; id_valid = 1'b1; ex_br_taken = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bundles", 32'({ex_ctrl, mem_ctrl, wb_ctrl}), 32'h0);
    chk("rst_fields", 32'({ex_rs, ex_rt, mem_dst, wb_dst}), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_comb", 32'({id_jump, pc_hold, ifid_hold, ifid_flush}), 32'h0);
    rst_n = 1'b1;
    step(add3, 1'b1, 1'b0);
    chk("post_rst_reg_write", 32'(ex_ctrl[9]), 32'h1);
    chk("post_rst_alu_op", 32'(ex_ctrl[6:5]), 32'h2);
    drain();

    // Decode table
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].inst, 1'b1, 1'b0);
      chk({"tbl_jump_", tbl[i].name}, 32'(id_jump), 32'(tbl[i].jump));
      step(tbl[i].inst, 1'b1, 1'b0);
      chk({"tbl_ctrl_", tbl[i].name}, 32'(ex_ctrl), 32'(tbl[i].ctrl));
      step(32'h0, 1'b0, 1'b0);
      chk({"tbl_dst_", tbl[i].name}, 32'(mem_dst), 32'(tbl[i].dst));
    end
    drain();

    // Load-use: one-cycle stall, bubble, then WB forward
    step(lw5, 1'b1, 1'b0);
    drive(add6, 1'b1, 1'b0);
    chk("lu_hold", 32'({pc_hold, ifid_hold}), 32'h3);
    step(add6, 1'b1, 1'b0);
    chk("lu_bubble", 32'(ex_ctrl), 32'h0);
    drive(add6, 1'b1, 1'b0);
    chk("lu_release", 32'({pc_hold, ifid_hold}), 32'h0);
    step(add6, 1'b1, 1'b0);
    chk("lu_fwd_a", 32'(fwd_a), 32'h1);
    drain();

    // Back-to-back MEM forwarding, and $0 never forwards
    step(rtype(1, 2, 4, 6'h20), 1'b1, 1'b0);
    step(rtype(4, 4, 7, 6'h22), 1'b1, 1'b0);
    chk("b2b_fwd", 32'({fwd_a, fwd_b}), 32'hA);
    drain();
    step(rtype(1, 2, 0, 6'h20), 1'b1, 1'b0);
    step(rtype(0, 0, 5, 6'h20), 1'b1, 1'b0);
    chk("zero_fwd", 32'({fwd_a, fwd_b}), 32'h0);
    drain();

    // Taken branch beats a same-cycle load-use stall
    step(lw5, 1'b1, 1'b0);
    drive(add6, 1'b1, 1'b1);
    chk("br_comb{flush,pc_hold,ifid_hold,jump}", 32'({ifid_flush, pc_hold, ifid_hold, id_jump}), 32'h8);
    step(add6, 1'b1, 1'b1);
    chk("br_bubble", 32'(ex_ctrl), 32'h0);
    drain();

    // JR waits two cycles behind a producer of rs
    step(rtype(1, 2, 9, 6'h20), 1'b1, 1'b0);
    drive(rtype(9, 0, 0, 6'h08), 1'b1, 1'b0);
    chk("jr_stall1", 32'({pc_hold, id_jump}), 32'h2);
    step(rtype(9, 0, 0, 6'h08), 1'b1, 1'b0);
    drive(rtype(9, 0, 0, 6'h08), 1'b1, 1'b0);
    chk("jr_stall2", 32'({pc_hold, id_jump}), 32'h2);
    step(rtype(9, 0, 0, 6'h08), 1'b1, 1'b0);
    drive(rtype(9, 0, 0, 6'h08), 1'b1, 1'b0);
    chk("jr_go", 32'({pc_hold, id_jump, id_jr}), 32'h3);
    step(rtype(9, 0, 0, 6'h08), 1'b1, 1'b0);
    drain();

    // jal: jump + flush now, link write reaches WB three edges later
    drive(jtype(6'h03, 26'h0000040), 1'b1, 1'b0);
    chk("jal_comb", 32'({id_jump, ifid_flush}), 32'h3);
    step(jtype(6'h03, 26'h0000040), 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("jal_wb", 32'({wb_dst, wb_ctrl[9]}), 32'({5'd31, 1'b1}));
    drain();

    // Randomized stream; the bench plays the IF stage honouring hold/flush
    cur_inst = rand_inst(); cur_v = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      br = ($urandom_range(0, 9) == 0);
      step(cur_inst, cur_v, br);
      if (!last_hold) begin
        if (last_flush) begin
          cur_inst = 32'h0; cur_v = 1'b0;
        end else begin
          cur_inst = rand_inst(); cur_v = ($urandom_range(0, 7) != 0);
        end
      end
    end

    // Mid-operation reset discards in-flight work at once
    step(add3, 1'b1, 1'b0);
    step(rtype(3, 3, 4, 6'h20), 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bundles", 32'({ex_ctrl, mem_ctrl, wb_ctrl}), 32'h0);
    chk("async_rst_fields", 32'({ex_rs, ex_rt, mem_dst, wb_dst}), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal opcode: bubble and sticky flag
    step(32'hFC000000, 1'b1, 1'b0);
    chk("ill_bubble", 32'(ex_ctrl), 32'h0);
    chk("ill_set", 32'(illegal), 32'h1);
    step(rtype(1, 2, 3, 6'h3F), 1'b1, 1'b0);
    step(add3, 1'b1, 1'b0);
    drain();
    chk("ill_sticky", 32'(illegal), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ill_cleared", 32'(illegal), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Parametrised pipelined control unit for the MIPS pipeline. It decodes the ID-stage instruction into a packed control bundle and carries the bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use and jump-register hazards, generates pipeline hold and flush signals, and drives EX-stage forwarding selects. The datapath keeps the data registers; this block owns every control bit that travels down the pipe.

## Interface
Parameters:
- REG_AW, 5: register index width.
- LINK_REG, 31: destination register for JAL.
- FWD_EN, 1: 1 enables forwarding; 0 forces fwd_* to 00 and stalls on every RAW hazard.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- id_inst  in  32  instruction held in IF/ID.
- id_valid  in  1  id_inst holds a real instruction.
- ex_br_taken  in  1  BEQ in EX resolved as taken.
- id_jump  out  1  J/JAL/JR in ID, PC mux select; combinational.
- id_jr  out  1  jump target comes from rs; combinational.
- pc_hold  out  1  freeze PC.
- ifid_hold  out  1  freeze IF/ID.
- ifid_flush  out  1  zero IF/ID on the next edge.
- ex_ctrl  out  CTRL_W  ID/EX control bundle.
- mem_ctrl  out  CTRL_W  EX/MEM control bundle.
- wb_ctrl  out  CTRL_W  MEM/WB control bundle.
- ex_rs, ex_rt  out  REG_AW  source indices in EX.
- mem_dst, wb_dst  out  REG_AW  write destination per stage.
- fwd_a, fwd_b  out  2  operand selects: 00 regfile, 01 WB, 10 MEM.
- illegal  out  1  sticky, set by an undecodable valid instruction.

## Operation
- Decode. Supported instructions: add, sub, and, or, slt, jr, nop, addi, slti, lw, sw, beq, j, jal.
- Bundle fields: reg_dst, jal, reg_write, slt, alu_src, alu_op[1:0], branch, jump, mem_read, mem_write, mem_to_reg. CTRL_W is 12.
- alu_op encoding: 0 add, 1 sub, 2 func-decode, 3 nop.
  - R-type uses 2.
  - addi, lw, sw use 0.
  - slti, beq use 1.
  - j, jal, nop use 3.
- Destination:
  - R-type: rd.
  - jal: LINK_REG.
  - otherwise: rt.
- A bubble is an all-zero bundle with dst = 0.
- An unknown opcode, or an unknown func with opcode 0, decodes to a bubble and sets illegal when id_valid = 1. id_valid = 0 also decodes to a bubble.
- Sources:
  - rs is used by every instruction except j, jal and nop.
  - rt is used by R-type, beq and sw.
- Load-use stall, when HAZARD applies: ex_ctrl.mem_read, ex dst != 0, and ex dst equals a used ID source. Action: pc_hold = ifid_hold = 1 and a bubble is inserted into ID/EX.
- JR stall: jr in ID while EX or MEM has reg_write with dst equal to rs and dst != 0. Action is the same as load-use.
- FWD_EN = 0 stall: also stall while EX or MEM has reg_write with dst equal to a used ID source and dst != 0.
- Jump: id_jump = 1 for j/jal/jr in ID when not stalled. This sets ifid_flush = 1, and the jump itself advances.
- Taken branch: ex_br_taken sets ifid_flush = 1, loads a bubble into ID/EX, and deasserts id_jump, pc_hold and ifid_hold.
- Priority: taken branch > stall > jump.
- Forwarding for each of ex_rs and ex_rt:
  - 10 if mem reg_write, mem_dst != 0 and mem_dst matches;
  - else 01 if wb reg_write, wb_dst != 0 and wb_dst matches;
  - else 00.
  - MEM wins over WB.
- Register 0 never causes a hazard or a forward.

## Timing
- ID decode is combinational to id_jump, id_jr, pc_hold, ifid_hold and ifid_flush.
- The bundle appears on ex_ctrl one edge after the instruction is in ID, then on mem_ctrl one edge later, then on wb_ctrl one edge after that.
- EX/MEM and MEM/WB always advance; only ID/EX takes bubbles.
- The load-use stall lasts exactly 1 cycle. The JR stall lasts up to 2 cycles with FWD_EN = 1.
- fwd_a and fwd_b are combinational from the registered stage state.
- Reset (async assert, release synchronous to clk):
  - all bundles zero, all dst and rs/rt fields zero;
  - illegal = 0.
  - Combinational outputs follow the decode of id_inst; with id_valid low they are 0.
- Asserting rst_n mid-operation discards in-flight instructions immediately.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode and func constants;
  - alu_op encodings;
  - bundle field bit positions and CTRL_W;
  - forwarding select constants.
- Sub-module ctrl_decoder holds the combinational decode: id_inst and id_valid in; bundle, dst select, used-source flags and illegal out.
- The hazard, forwarding and stage registers live in the top module.

## Test plan
- Reset: hold rst_n = 0 with id_inst = add $3,$1,$2 and id_valid = 1 → all bundles 0 and illegal = 0. After release, ex_ctrl.reg_write = 1 and ex alu_op = 2 one edge later.
- Load-use: lw $5,0($1) followed by add $6,$5,$2 → pc_hold = ifid_hold = 1 for one cycle and a bubble in ID/EX. Then fwd_a = 01 when the add is in EX.
- Back-to-back forwarding: add $4,$1,$2, then sub $7,$4,$4 → fwd_a = fwd_b = 10. Writes to $0 give 00.
- Taken branch with a same-cycle load-use candidate in ID → ifid_flush = 1, pc_hold = 0, ID/EX bubble.
- jal: id_jump = 1 and ifid_flush = 1. wb_dst = 31 and wb_ctrl.reg_write = 1 three edges later.
- id_inst = 0xFC000000 with id_valid = 1 → bubble and illegal = 1. illegal stays 1 until rst_n is asserted.
